regfile_arbiter: RTL
====================

Name: regfile_arbiter

Overview:
- Shares the single-port register file between two bus masters (m0, m1) using a request/grant handshake.
- Round-robin arbitration with a bounded hold time.
- The granted master's addr/d_in/we_ are muxed onto the register file port; the read data is returned to both masters.
- Sits between the masters (e.g. CPU debug path and DMA/config engine) and the regfile instance.

Parameters:
- DATA_W, 32, data width; must match the regfile.
- ADDR_W, 5, address width; must match the regfile.
- MAX_HOLD, 8, maximum consecutive cycles one master keeps the grant while the other is requesting (>=1).

Ports:
- clk  in  1  clock; single clock domain.
- reset_  in  1  asynchronous reset, active-low.
- m0_req_  in  1  master 0 request, active-low.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wr_data  in  DATA_W  master 0 write data.
- m0_we_  in  1  master 0 write enable, active-low; honoured only while granted.
- m0_grnt_  out  1  master 0 grant, active-low, registered.
- m1_req_, m1_addr, m1_wr_data, m1_we_, m1_grnt_: same as m0 for master 1.
- rd_data  out  DATA_W  = rf_d_out; valid for the owner while granted.
- rf_addr  out  ADDR_W  regfile address.
- rf_d_in  out  DATA_W  regfile write data.
- rf_we_  out  1  regfile write enable, active-low.
- rf_d_out  in  DATA_W  regfile combinational read data.

Behaviour:
- **Reset**
  - m0_grnt_ = m1_grnt_ = 1 (disabled).
  - owner = none; last_owner = m1, so m0 wins the first tie.
  - hold_cnt = 0.
  - rf_we_ = 1, rf_addr = 0, rf_d_in = 0.
- **FSM states:** IDLE, OWN0, OWN1. Grants are decoded from the state (OWN0 -> m0_grnt_=0), so they are registered.
- **IDLE**
  - Single request -> OWN of that master.
  - Both requesting -> the master != last_owner.
  - No request -> stay IDLE.
- **OWNx, leaving the state**
  - If mx_req_ deasserted (1): go directly to OWNy when y is requesting (no idle bubble), else go to IDLE. last_owner <= x.
  - If mx_req_ asserted, y requesting, and hold_cnt == MAX_HOLD-1: preempt to OWNy. last_owner <= x.
- **OWNx, staying**
  - Otherwise stay in OWNx.
  - hold_cnt increments only while y is requesting; otherwise it holds at 0.
  - hold_cnt resets to 0 on every state change.
- **Latency**
  - Request sampled at edge n -> grant low after edge n.
  - The master may access starting in the cycle after it sees grant low.
  - Access latency through the arbiter is 0 cycles:
    - rf_addr/rf_d_in/rf_we_ are combinational muxes of the owner's inputs.
    - The write commits on the next regfile clk edge.
    - rd_data is combinational in the same cycle.
- **No owner (IDLE):** rf_we_ = 1, rf_addr = 0, rf_d_in = 0.
- **Non-owner inputs:** a non-owner's we_ never reaches the regfile.
- **Preemption**
  - A master must check grant each cycle.
  - A write issued in the cycle grant is still low commits; in the cycle after, the grant is gone.
- **Simultaneous release + request by the same master:** treated as release (edge-sampled), so round-robin fairness applies.
- **Reset mid-operation:** grants drop asynchronously and rf_we_ goes 1 immediately, so no partial write is possible.
- **MAX_HOLD = 1:** the grant alternates every cycle while both request.

Decomposition:
- Shared header (regfile.h): DATA_W/ADDR_W width macros, ENABLE_/DISABLE_ levels, and state encodings ARB_IDLE/ARB_OWN0/ARB_OWN1 (2 bits).
- One natural sub-module: regfile_arb_mux, the combinational owner-select mux for addr/d_in/we_. The FSM and hold counter stay in the top module.

Test Plan:
- **Reset:** hold reset_=0 with both req_=0 -> both grants 1, rf_we_=1; release reset -> m0_grnt_=0 after the first edge (tie goes to m0).
- **Write/read through m0:** m0 granted; write addr 3 data 0xDEADBEEF with m0_we_=0 for one cycle; next cycle read addr 3 -> rd_data=0xDEADBEEF.
- **Handover:** m0 holds, m1 requests, m0 releases at edge n -> m1_grnt_=0 after edge n with no IDLE cycle; m0_grnt_=1 in the same cycle.
- **Preemption:** both continuously request, MAX_HOLD=8 -> grant alternates every 8 cycles; hold_cnt wraps to 0.
- **Isolation:** m1 not granted drives m1_we_=0 to addr 3 data 0x12345678 -> addr 3 is unchanged (still 0xDEADBEEF).
- **Async reset:** assert reset_ mid-cycle during an m1 write -> m1_grnt_ and rf_we_ go 1 before the next edge; no write occurs.

Source files
------------

// File: rtl/regfile_arbiter_pkg.sv
// Shared widths, active-low enable levels and arbiter state encoding for the
// register-file arbiter slice.
package regfile_arbiter_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile_arbiter_if.sv
// One master's request/grant and access bus toward the register-file arbiter.
interface regfile_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req_;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              we_;
  logic              grnt_;

  modport master (output req_, output addr, output wr_data, output we_, input grnt_);
  modport slave  (input req_, input addr, input wr_data, input we_, output grnt_);
endinterface

// File: rtl/regfile_arb_mux.sv
// Owner-select mux onto the register-file port; with no owner the port is
// parked at address 0 with writes disabled.
module regfile_arb_mux
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  arb_state_t        state,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] d_in0,
  input  logic              we0_,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] d_in1,
  input  logic              we1_,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_
);

  always_comb begin
    rf_addr = '0;
    rf_d_in = '0;
    rf_we_  = DISABLE_;
    case (state)
      ARB_OWN0: begin
        rf_addr = addr0;
        rf_d_in = d_in0;
        rf_we_  = we0_;
      end
      ARB_OWN1: begin
        rf_addr = addr1;
        rf_d_in = d_in1;
        rf_we_  = we1_;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one single-port register file between two
// masters, with a bounded hold time while the other master is waiting.
//
// state    | meaning
// ARB_IDLE | no owner, regfile port parked (we_ high, addr/data 0)
// ARB_OWN0 | master 0 granted, its bus drives the regfile
// ARB_OWN1 | master 1 granted, its bus drives the regfile
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset_,
  regfile_arbiter_if.slave  m0,
  regfile_arbiter_if.slave  m1,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_,
  input  logic [DATA_W-1:0] rf_d_out
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_t       state_q, state_d;
  logic             last_owner_q, last_owner_d;  // 0 = m0, 1 = m1
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             req0, req1;

  assign req0 = (m0.req_ == ENABLE_);
  assign req1 = (m1.req_ == ENABLE_);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ARB_IDLE: begin
        if (req0 && req1) state_d = last_owner_q ? ARB_OWN0 : ARB_OWN1;
        else if (req0)    state_d = ARB_OWN0;
        else if (req1)    state_d = ARB_OWN1;
      end
      ARB_OWN0: begin
        if (!req0) begin
          state_d      = req1 ? ARB_OWN1 : ARB_IDLE;
          last_owner_d = 1'b0;
        end else if (req1 && hold_cnt_q == HOLD_LAST) begin
          state_d      = ARB_OWN1;
          last_owner_d = 1'b0;
        end
      end
      ARB_OWN1: begin
        if (!req1) begin
          state_d      = req0 ? ARB_OWN0 : ARB_IDLE;
          last_owner_d = 1'b1;
        end else if (req0 && hold_cnt_q == HOLD_LAST) begin
          state_d      = ARB_OWN0;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Hold time only accumulates while the other master is actually waiting.
  always_comb begin
    hold_cnt_d = '0;
    if (state_d == state_q) begin
      if ((state_q == ARB_OWN0 && req1) || (state_q == ARB_OWN1 && req0))
        hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  assign m0.grnt_ = (state_q == ARB_OWN0) ? ENABLE_ : DISABLE_;
  assign m1.grnt_ = (state_q == ARB_OWN1) ? ENABLE_ : DISABLE_;
  assign rd_data  = rf_d_out;

  regfile_arb_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mux (
    .state   (state_q),
    .addr0   (m0.addr),
    .d_in0   (m0.wr_data),
    .we0_    (m0.we_),
    .addr1   (m1.addr),
    .d_in1   (m1.wr_data),
    .we1_    (m1.we_),
    .rf_addr (rf_addr),
    .rf_d_in (rf_d_in),
    .rf_we_  (rf_we_)
  );

endmodule
